passcode_lock_core: RTL
=======================

Name: passcode_lock_core

Overview:
- Parametrised successor to the fixed 12-bit passcode holding register.
- Stores a DIGITS x DIGIT_W passcode and collects digits one at a time.
- Verifies each complete entry against the stored code; reprograms the code only while unlocked.
- Enforces a lockout window after MAX_TRIES consecutive failures; sits between keypad decode and the lock actuator/display logic.

Parameters:
- DIGITS, 3, number of digits per code
- DIGIT_W, 4, bits per digit
- MAX_TRIES, 3, consecutive failed verifies that trigger lockout (>=1)
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (>=1)
- RESET_CODE, 0, stored code after reset (DIGITS*DIGIT_W bits)

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- digit_in  in  DIGIT_W  digit value; first digit entered ends up in the MS digit
- digit_valid  in  1  accept digit_in this cycle
- mode  in  1  1 = program, 0 = verify; only meaningful in UNLOCKED
- clear  in  1  discard the partial entry
- relock  in  1  leave UNLOCKED
- code_out  out  DIGITS*DIGIT_W  stored code
- unlocked  out  1  high while in UNLOCKED
- locked_out  out  1  high while in LOCKOUT
- fail_pulse  out  1  1-cycle pulse on a failed verify
- prog_done  out  1  1-cycle pulse when a new code is stored
- digit_count  out  clog2(DIGITS+1)  digits held in the entry buffer

Behaviour:
- Reset (synchronous, any state, mid-operation included):
  - state=ENTRY; code_out=RESET_CODE.
  - Entry buffer=0, digit_count=0, fail count=0, lockout timer=0.
  - All pulses and flags 0.
- Entry buffer: each accepted digit shifts in at the LS digit (buffer <= {buffer, digit_in}), count+1.
- Completion: the cycle in which the accepted digit makes count reach DIGITS. The comparison/store uses the buffer including that digit.
- ENTRY (verify):
  - digit_valid is accepted; mode is ignored.
  - On completion with match: next cycle state=UNLOCKED, unlocked=1, fail count=0, buffer/count cleared.
  - On completion with mismatch: next cycle fail_pulse=1, fail count+1, buffer/count cleared.
  - If the incremented fail count equals MAX_TRIES: state=LOCKOUT, timer=LOCKOUT_CYCLES, fail_pulse still asserted that cycle.
- LOCKOUT:
  - locked_out=1.
  - digit_valid, clear, relock and mode are all ignored.
  - Timer decrements every cycle. When timer==1, next state=ENTRY, fail count=0.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- UNLOCKED:
  - mode=0: digit_valid ignored.
  - mode=1: digits accumulate. On completion, next cycle code_out=new code, prog_done=1, state=ENTRY, unlocked=0.
  - mode is sampled per digit. A mode drop mid-entry discards the partial entry (buffer/count cleared).
  - relock: next cycle state=ENTRY, partial entry discarded; relock has priority over digit_valid.
- clear: in ENTRY/UNLOCKED, buffer and count go to 0 next cycle; clear has priority over digit_valid in the same cycle (digit dropped).
- Priority: Reset > LOCKOUT ignore > relock > clear > digit_valid.
- Hold: code_out changes only on prog_done or Reset. No digit_valid means all registers hold.
- Latency: unlocked/fail_pulse/prog_done/locked_out assert on the first clock edge after the completing digit.
- digit_count never exceeds DIGITS-1 when observed; it returns to 0 on completion.

Test Plan:
(DIGITS=3, DIGIT_W=4, MAX_TRIES=3, LOCKOUT_CYCLES=16, RESET_CODE=0)
- Reset, enter 0,0,0 -> unlocked=1 the cycle after the 3rd digit; code_out=12'h000; fail_pulse never asserted.
- While unlocked, mode=1, enter 4,7,2 -> prog_done one cycle, code_out=12'h472, unlocked=0; then verify 4,7,2 -> unlocked=1.
- Code 472, enter 1,2,3 three times:
  - fail_pulse once per attempt.
  - After the 3rd attempt, locked_out=1 for exactly 16 cycles; digits entered meanwhile are ignored (digit_count stays 0).
  - Afterwards, 4,7,2 unlocks.
- Enter 4,7, assert clear -> digit_count=0. Next cycle clear and digit_valid(4) together -> digit dropped, digit_count=0. Then 4,7,2 -> unlocked.
- Sequence fail, fail, 4,7,2 (unlock), relock, fail -> no lockout; fail count was cleared by the success.
- Program 4,7,2, then assert Reset mid-entry (after 1 digit) and separately mid-lockout -> code_out=12'h000, all flags 0, digit_count=0, state ENTRY.

Source files
------------

// File: rtl/passcode_lock_core_if.sv
// passcode_lock_core_if: keypad-side and status-side signals of passcode_lock_core.
//   i_digit_in     digit value, first digit ends up in the MS digit
//   i_digit_valid  accept i_digit_in this cycle
//   i_mode         1 = program, 0 = verify (only meaningful while unlocked)
//   i_clear        discard the partial entry
//   i_relock       leave the unlocked state
//   o_code_out     stored code
//   o_unlocked     high while unlocked
//   o_locked_out   high while in lockout
//   o_fail_pulse   1-cycle pulse on a failed verify
//   o_prog_done    1-cycle pulse when a new code is stored
//   o_digit_count  digits held in the entry buffer
// master = keypad/controller side, slave = the lock core.
interface passcode_lock_core_if #(
   parameter int unsigned DIGITS  = 3,
   parameter int unsigned DIGIT_W = 4
);
   localparam int unsigned CODE_W = DIGITS * DIGIT_W;
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

   logic [DIGIT_W-1:0] i_digit_in;
   logic               i_digit_valid;
   logic               i_mode;
   logic               i_clear;
   logic               i_relock;
   logic [CODE_W-1:0]  o_code_out;
   logic               o_unlocked;
   logic               o_locked_out;
   logic               o_fail_pulse;
   logic               o_prog_done;
   logic [CNT_W-1:0]   o_digit_count;

   modport master (
      output i_digit_in, i_digit_valid, i_mode, i_clear, i_relock,
      input  o_code_out, o_unlocked, o_locked_out, o_fail_pulse, o_prog_done, o_digit_count
   );

   modport slave (
      input  i_digit_in, i_digit_valid, i_mode, i_clear, i_relock,
      output o_code_out, o_unlocked, o_locked_out, o_fail_pulse, o_prog_done, o_digit_count
   );
endinterface

// File: rtl/passcode_lock_core.sv
// passcode_lock_core: collects keypad digits, verifies complete entries against a stored
// DIGITS x DIGIT_W code, reprograms the code while unlocked, and enforces a lockout window
// after MAX_TRIES consecutive failed verifies.
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   io_bus   slave side of passcode_lock_core_if (digit input, controls, status outputs)
module passcode_lock_core #(
   parameter int unsigned                  DIGITS         = 3,
   parameter int unsigned                  DIGIT_W        = 4,
   parameter int unsigned                  MAX_TRIES      = 3,
   parameter int unsigned                  LOCKOUT_CYCLES = 16,
   parameter logic [DIGITS*DIGIT_W-1:0]    RESET_CODE     = '0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   passcode_lock_core_if.slave   io_bus
);
   localparam int unsigned CODE_W = DIGITS * DIGIT_W;
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
   localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
   localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [1:0] {StEntry, StUnlocked, StLockout} state_e;

   state_e              r_state;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   r_buf;
   logic [CNT_W-1:0]    r_cnt;
   logic [FAIL_W-1:0]   r_fails;
   logic [TMR_W-1:0]    r_timer;
   logic                r_fail_pulse;
   logic                r_prog_done;

   state_e              w_state_nxt;
   logic [CODE_W-1:0]   w_code_nxt;
   logic [CODE_W-1:0]   w_buf_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [FAIL_W-1:0]   w_fails_nxt;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic                w_fail_pulse_nxt;
   logic                w_prog_done_nxt;

   logic [CODE_W-1:0]   w_buf_shift;
   logic [FAIL_W-1:0]   w_fails_inc;
   logic                w_complete;

   // New digit enters at the LS end, so the first digit typed ends up most significant.
   assign w_buf_shift = (r_buf << DIGIT_W) | CODE_W'(io_bus.i_digit_in);
   assign w_fails_inc = r_fails + FAIL_W'(1);
   // The accepted digit this cycle would be the last one of the code.
   assign w_complete  = (r_cnt == CNT_W'(DIGITS - 1));

   always_comb begin
      w_state_nxt      = r_state;
      w_code_nxt       = r_code;
      w_buf_nxt        = r_buf;
      w_cnt_nxt        = r_cnt;
      w_fails_nxt      = r_fails;
      w_timer_nxt      = r_timer;
      w_fail_pulse_nxt = 1'b0;
      w_prog_done_nxt  = 1'b0;

      unique case (r_state)
         StEntry: begin
            if (io_bus.i_clear) begin
               w_buf_nxt = '0;
               w_cnt_nxt = '0;
            end else if (io_bus.i_digit_valid) begin
               if (w_complete) begin
                  w_buf_nxt = '0;
                  w_cnt_nxt = '0;
                  if (w_buf_shift == r_code) begin
                     w_state_nxt = StUnlocked;
                     w_fails_nxt = '0;
                  end else begin
                     w_fail_pulse_nxt = 1'b1;
                     w_fails_nxt      = w_fails_inc;
                     if (w_fails_inc == FAIL_W'(MAX_TRIES)) begin
                        w_state_nxt = StLockout;
                        w_timer_nxt = TMR_W'(LOCKOUT_CYCLES);
                     end
                  end
               end else begin
                  w_buf_nxt = w_buf_shift;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end

         StUnlocked: begin
            if (io_bus.i_relock) begin
               w_state_nxt = StEntry;
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (io_bus.i_clear) begin
               w_buf_nxt = '0;
               w_cnt_nxt = '0;
            end else if (io_bus.i_digit_valid) begin
               if (!io_bus.i_mode) begin
                  // Verify-mode digit while unlocked: dropped, and any partial program
                  // entry is abandoned.
                  w_buf_nxt = '0;
                  w_cnt_nxt = '0;
               end else if (w_complete) begin
                  w_code_nxt      = w_buf_shift;
                  w_prog_done_nxt = 1'b1;
                  w_state_nxt     = StEntry;
                  w_buf_nxt       = '0;
                  w_cnt_nxt       = '0;
               end else begin
                  w_buf_nxt = w_buf_shift;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end

         StLockout: begin
            // All keypad inputs are ignored; only the timer runs.
            w_timer_nxt = r_timer - TMR_W'(1);
            if (r_timer == TMR_W'(1)) begin
               w_state_nxt = StEntry;
               w_fails_nxt = '0;
            end
         end

         default: begin
            w_state_nxt = StEntry;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StEntry;
         r_code       <= RESET_CODE;
         r_buf        <= '0;
         r_cnt        <= '0;
         r_fails      <= '0;
         r_timer      <= '0;
         r_fail_pulse <= 1'b0;
         r_prog_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_code       <= w_code_nxt;
         r_buf        <= w_buf_nxt;
         r_cnt        <= w_cnt_nxt;
         r_fails      <= w_fails_nxt;
         r_timer      <= w_timer_nxt;
         r_fail_pulse <= w_fail_pulse_nxt;
         r_prog_done  <= w_prog_done_nxt;
      end
   end

   assign io_bus.o_code_out    = r_code;
   assign io_bus.o_unlocked    = (r_state == StUnlocked);
   assign io_bus.o_locked_out  = (r_state == StLockout);
   assign io_bus.o_fail_pulse  = r_fail_pulse;
   assign io_bus.o_prog_done   = r_prog_done;
   assign io_bus.o_digit_count = r_cnt;
endmodule
